// File: rtl/mvmul_pkg.sv
// Shared types and sizing constants for the mvmul_arbiter block.
// Contents:
//   mvarb_state_t  sequencer states, from arbitration through result return
//   MV_IN_WORDS    words per job sent to the wrapper (16 matrix + 4 vector)
//   MV_OUT_WORDS   result words per job
//   MV_WCNT_W      width of the input-side word counters
//   MV_RCNT_W      width of the result-side word counters
package mvmul_pkg;

  typedef enum logic [2:0] {
    ARB,
    COLLECT,
    START,
    BURST,
    WAIT_RES,
    RELEASE,
    RETURN
  } mvarb_state_t;

  localparam int MV_IN_WORDS  = 20;
  localparam int MV_OUT_WORDS = 4;
  localparam int MV_WCNT_W    = 5;
  localparam int MV_RCNT_W    = 2;

endpackage

// File: rtl/mvmul_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
// Returns a one-hot grant for the first set bit of req found when scanning
// upward from index ptr and wrapping modulo NUM_REQ. All zeros if req is 0.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    index that has highest priority this cycle
//   gnt  out NUM_REQ  one-hot winner, or zero
module rr_arbiter
  import mvmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mvmul_arbiter.sv
// mvmul_arbiter: shares one mul4x4_4x1_wrapper among NUM_REQ requesters.
// A round-robin winner streams its 20 input words into a local buffer; the
// buffer is then replayed to the wrapper as one gapless burst (the wrapper
// does not qualify its load with data_valid), the 4 results are captured,
// the wrapper is released, and the results are returned with backpressure.
// Ports:
//   iClk, iRstn            clock, synchronous active-low reset
//   req_valid[NUM_REQ]     job request, held until the rsp_last handshake
//   req_wvalid[NUM_REQ]    input word strobe per requester
//   req_wdata[NUM_REQ*32]  packed input words, slice i for requester i
//   req_wready             input word accept for the granted requester
//   grant[NUM_REQ]         one-hot grant
//   rsp_valid[NUM_REQ]     result valid, only on the granted bit
//   rsp_data, rsp_last     result word and end-of-result marker
//   rsp_ready[NUM_REQ]     result accept per requester
//   mv_*                   wrapper handshake (ready/data_valid/data/
//                          calc_done/result/read_done)
//   busy                   sequencer is not arbitrating
//   job_count              completed jobs, wrapping 16-bit counter
module mvmul_arbiter
  import mvmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      iClk,
  input  logic                      iRstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wvalid,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic                      req_wready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  input  logic                      mv_ready,
  output logic                      mv_data_valid,
  output logic [DATA_W-1:0]         mv_data,
  input  logic                      mv_calc_done,
  input  logic [DATA_W-1:0]         mv_result,
  output logic                      mv_read_done,
  output logic                      busy,
  output logic [15:0]               job_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [MV_WCNT_W-1:0] LAST_IN  = MV_WCNT_W'(MV_IN_WORDS - 1);
  localparam logic [MV_RCNT_W-1:0] LAST_OUT = MV_RCNT_W'(MV_OUT_WORDS - 1);

  mvarb_state_t state, nxt;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gidx;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     ptr_nxt;
  logic [NUM_REQ-1:0]   pick;
  logic [MV_WCNT_W-1:0] wcnt;
  logic [MV_WCNT_W-1:0] bcnt;
  logic [MV_RCNT_W-1:0] rcnt;
  logic [MV_RCNT_W-1:0] ocnt;

  logic [DATA_W-1:0] in_buf  [MV_IN_WORDS];
  logic [DATA_W-1:0] out_buf [MV_OUT_WORDS];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  logic word_take;
  logic res_take;
  logic rsp_take;
  logic abort;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) state <= ARB;
    else        state <= nxt;
  end

  // Next state and all handshake outputs decode from the current state, so a
  // reset forces every output to its idle value on the same edge.
  always_comb begin
    nxt           = state;
    req_wready    = 1'b0;
    mv_data_valid = 1'b0;
    mv_data       = '0;
    mv_read_done  = 1'b0;
    rsp_valid     = '0;
    rsp_data      = '0;
    rsp_last      = 1'b0;
    word_take     = 1'b0;
    res_take      = 1'b0;
    rsp_take      = 1'b0;
    abort         = 1'b0;
    case (state)
      ARB: begin
        if (|req_valid) nxt = COLLECT;
      end
      COLLECT: begin
        req_wready = 1'b1;
        if (!req_valid[gidx]) begin
          abort = 1'b1;
          nxt   = ARB;
        end else if (req_wvalid[gidx]) begin
          word_take = 1'b1;
          if (wcnt == LAST_IN) nxt = START;
        end
      end
      START: begin
        // Zero-data strobe that kicks the wrapper out of IDLE.
        if (mv_ready) begin
          mv_data_valid = 1'b1;
          nxt           = BURST;
        end
      end
      BURST: begin
        mv_data_valid = 1'b1;
        mv_data       = in_buf[bcnt];
        if (bcnt == LAST_IN) nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (mv_calc_done) begin
          res_take = 1'b1;
          if (rcnt == LAST_OUT) nxt = RELEASE;
        end
      end
      RELEASE: begin
        mv_read_done = 1'b1;
        nxt          = RETURN;
      end
      RETURN: begin
        rsp_valid = grant;
        rsp_data  = out_buf[ocnt];
        rsp_last  = (ocnt == LAST_OUT);
        if (rsp_ready[gidx]) begin
          rsp_take = 1'b1;
          if (ocnt == LAST_OUT) nxt = ARB;
        end
      end
      default: nxt = ARB;
    endcase
  end

  assign busy = (state != ARB);

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      ocnt      <= '0;
      job_count <= '0;
    end else begin
      case (state)
        ARB: begin
          if (|req_valid) begin
            grant  <= pick;
            gidx   <= pick_idx;
            rr_ptr <= ptr_nxt;
            wcnt   <= '0;
            bcnt   <= '0;
            rcnt   <= '0;
            ocnt   <= '0;
          end
        end
        COLLECT: begin
          if (abort)          grant <= '0;
          else if (word_take) wcnt  <= wcnt + MV_WCNT_W'(1);
        end
        BURST:    bcnt <= bcnt + MV_WCNT_W'(1);
        WAIT_RES: if (res_take) rcnt <= rcnt + MV_RCNT_W'(1);
        RETURN: begin
          if (rsp_take) begin
            ocnt <= ocnt + MV_RCNT_W'(1);
            if (ocnt == LAST_OUT) begin
              grant     <= '0;
              job_count <= job_count + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Word buffers carry no reset; they are always written before being read.
  always_ff @(posedge iClk) begin
    if (word_take) in_buf[wcnt]  <= wdata_arr[gidx];
    if (res_take)  out_buf[rcnt] <= mv_result;
  end

endmodule

// File: tb/tb_mvmul_arbiter.sv
module tb_mvmul_arbiter;

  localparam int NR = 4;

  logic              clk;
  logic              iRstn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_wvalid;
  logic [NR*32-1:0]  req_wdata;
  logic              req_wready;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic [NR-1:0]     rsp_ready;
  logic              mv_ready;
  logic              mv_data_valid;
  logic [31:0]       mv_data;
  logic              mv_calc_done;
  logic [31:0]       mv_result;
  logic              mv_read_done;
  logic              busy;
  logic [15:0]       job_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] words [NR][20];
  logic [31:0] got  [4];
  logic        gotl [4];
  int          unstable;
  int          rd_at_hs;

  logic [31:0] exp_id  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] exp_x2  [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
  logic [31:0] exp_x3  [4] = '{32'h40400000, 32'h40C00000, 32'h41100000, 32'h41400000};
  logic [31:0] exp_rev [4] = '{32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

  mvmul_arbiter #(.NUM_REQ(NR), .DATA_W(32)) dut (
    .iClk          (clk),
    .iRstn         (iRstn),
    .req_valid     (req_valid),
    .req_wvalid    (req_wvalid),
    .req_wdata     (req_wdata),
    .req_wready    (req_wready),
    .grant         (grant),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_ready     (rsp_ready),
    .mv_ready      (mv_ready),
    .mv_data_valid (mv_data_valid),
    .mv_data       (mv_data),
    .mv_calc_done  (mv_calc_done),
    .mv_result     (mv_result),
    .mv_read_done  (mv_read_done),
    .busy          (busy),
    .job_count     (job_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wrapper model: single-precision conversion through double bit patterns.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0) d = 64'd0;
    else d = {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real x);
    logic [63:0] d;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  logic [31:0] mm   [20];
  logic [31:0] mres [4];
  int ms = 0, mlc = 0, gap_err = 0;
  localparam int M_IDLE = 0, M_LOAD = 1, M_CALC = 2, M_OUT = 3, M_WREAD = 4, M_POST = 5;

  function automatic logic [31:0] dot(input int row);
    real acc;
    acc = 0.0;
    for (int j = 0; j < 4; j++) acc = acc + s2r(mm[row*4+j]) * s2r(mm[16+j]);
    return r2s(acc);
  endfunction

  always @(posedge clk) begin
    if (!iRstn) begin
      ms <= M_IDLE; mv_ready <= 1'b1; mv_calc_done <= 1'b0; mv_result <= '0; mlc <= 0;
    end else begin
      case (ms)
        M_IDLE: if (mv_data_valid) begin ms <= M_LOAD; mv_ready <= 1'b0; mlc <= 0; end
        M_LOAD: begin
          if (!mv_data_valid) gap_err <= gap_err + 1;
          mm[mlc] <= mv_data;
          if (mlc == 19) begin ms <= M_CALC; mlc <= 0; end
          else mlc <= mlc + 1;
        end
        M_CALC: begin
          if (mlc == 2) begin
            for (int i = 0; i < 4; i++) mres[i] <= dot(i);
            ms <= M_OUT; mlc <= 0;
          end else mlc <= mlc + 1;
        end
        M_OUT: begin
          mv_calc_done <= 1'b1;
          mv_result    <= mres[mlc];
          if (mlc == 3) ms <= M_WREAD;
          mlc <= mlc + 1;
        end
        M_WREAD: begin
          mv_calc_done <= 1'b0; mv_result <= '0;
          if (mv_read_done) ms <= M_POST;
        end
        M_POST: begin mv_ready <= 1'b1; ms <= M_IDLE; end
        default: ms <= M_IDLE;
      endcase
    end
  end

  int run_cur = 0, last_run = 0, mdv_cnt = 0, rd_cnt = 0;
  always @(posedge clk) begin
    if (mv_data_valid) begin
      run_cur <= run_cur + 1;
      mdv_cnt <= mdv_cnt + 1;
    end else begin
      if (run_cur != 0) last_run <= run_cur;
      run_cur <= 0;
    end
    if (mv_read_done) rd_cnt <= rd_cnt + 1;
  end

  task automatic set_diag(input int r, input logic [31:0] d);
    for (int i = 0; i < 16; i++) words[r][i] = (i % 5 == 0) ? d : 32'h0;
    words[r][16] = 32'h3F800000; words[r][17] = 32'h40000000;
    words[r][18] = 32'h40400000; words[r][19] = 32'h40800000;
  endtask

  task automatic set_rev(input int r);
    for (int i = 0; i < 16; i++) words[r][i] = (i == 3 || i == 6 || i == 9 || i == 12) ? 32'h3F800000 : 32'h0;
    words[r][16] = 32'h3F800000; words[r][17] = 32'h40000000;
    words[r][18] = 32'h40400000; words[r][19] = 32'h40800000;
  endtask

  task automatic apply_reset();
    iRstn = 1'b0; req_valid = '0; req_wvalid = '0; rsp_ready = '0;
    repeat (3) @(negedge clk);
    iRstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed_words(input int r, input int n, input int gap);
    int k, t;
    k = 0; t = 0;
    while (k < n && t < 1000) begin
      req_wvalid = '0;
      if (req_wready && grant[r] && (gap <= 1 || (t % gap) == 0)) begin
        req_wvalid[r] = 1'b1;
        req_wdata[r*32 +: 32] = words[r][k];
        k++;
      end
      @(negedge clk);
      t++;
    end
    req_wvalid = '0;
  endtask

  task automatic do_job(input int gap, input int stall, input bit keep, output int r);
    int tmo;
    logic [31:0] hold;
    logic hl;
    r = -1; tmo = 0; unstable = 0; rd_at_hs = -1;
    hold = '0; hl = 1'b0;
    for (int k = 0; k < 4; k++) begin got[k] = 'x; gotl[k] = 1'bx; end
    while (grant == '0 && tmo < 50) begin @(negedge clk); tmo++; end
    for (int i = 0; i < NR; i++) if (grant[i]) r = i;
    if (r < 0) return;
    feed_words(r, 20, gap);
    tmo = 0;
    while (!rsp_valid[r] && tmo < 300) begin @(negedge clk); tmo++; end
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stall; s++) begin
        if (s == 0) begin hold = rsp_data; hl = rsp_last; end
        else if (rsp_data !== hold || rsp_last !== hl) unstable++;
        @(negedge clk);
      end
      if (stall > 0 && (rsp_data !== hold || rsp_last !== hl)) unstable++;
      if (!rsp_valid[r]) begin rsp_ready = '0; return; end
      if (k == 0) rd_at_hs = rd_cnt;
      got[k] = rsp_data; gotl[k] = rsp_last;
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready[r] = 1'b0;
    end
    if (!keep) req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    iRstn = 1'b0; req_valid = '0; req_wvalid = '0; req_wdata = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (grant !== '0) $display("FAIL rst_grant got=%b exp=0", grant); else n_pass++;
    n_checks++; if (req_wready !== 1'b0) $display("FAIL rst_wready got=%b exp=0", req_wready); else n_pass++;
    n_checks++; if (mv_data_valid !== 1'b0) $display("FAIL rst_mdv got=%b exp=0", mv_data_valid); else n_pass++;
    n_checks++; if (mv_read_done !== 1'b0) $display("FAIL rst_read_done got=%b exp=0", mv_read_done); else n_pass++;
    n_checks++; if (rsp_valid !== '0 || rsp_last !== 1'b0) $display("FAIL rst_rsp got=%b/%b exp=0/0", rsp_valid, rsp_last); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (job_count !== 16'd0) $display("FAIL rst_job_count got=%0d exp=0", job_count); else n_pass++;
    n_checks++; if (mv_data !== '0 || rsp_data !== '0) $display("FAIL rst_data got=%h/%h exp=0/0", mv_data, rsp_data); else n_pass++;
    iRstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int r, g0, rd0;
    set_diag(0, 32'h3F800000);
    g0 = gap_err; rd0 = rd_cnt;
    req_valid[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001) $display("FAIL id_grant_timing got=%b exp=0001", grant); else n_pass++;
    do_job(1, 0, 1'b0, r);
    n_checks++; if (r !== 0) $display("FAIL id_winner got=%0d exp=0", r); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got[k] !== exp_id[k]) $display("FAIL id_r%0d got=%h exp=%h", k, got[k], exp_id[k]); else n_pass++;
    end
    n_checks++; if (job_count !== 16'd1) $display("FAIL id_job_count got=%0d exp=1", job_count); else n_pass++;
    n_checks++; if (last_run !== 21) $display("FAIL id_mdv_run got=%0d exp=21", last_run); else n_pass++;
    n_checks++; if (gap_err !== g0) $display("FAIL id_burst_gaps got=%0d exp=%0d", gap_err, g0); else n_pass++;
    n_checks++; if (rd_cnt - rd0 !== 1) $display("FAIL id_read_done_pulses got=%0d exp=1", rd_cnt - rd0); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || grant !== '0) $display("FAIL id_idle got=%b/%b exp=0/0", busy, grant); else n_pass++;
  endtask

  task automatic test_round_robin();
    int r;
    int ord_exp [4] = '{0, 2, 0, 2};
    logic [31:0] e;
    apply_reset();
    set_diag(0, 32'h40000000);
    set_diag(2, 32'h40400000);
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      do_job(1, 0, 1'b1, r);
      n_checks++; if (r !== ord_exp[j]) $display("FAIL rr_order_job%0d got=%0d exp=%0d", j, r, ord_exp[j]); else n_pass++;
      for (int k = 0; k < 4; k++) begin
        e = (ord_exp[j] == 0) ? exp_x2[k] : exp_x3[k];
        n_checks++; if (got[k] !== e) $display("FAIL rr_job%0d_r%0d got=%h exp=%h", j, k, got[k], e); else n_pass++;
      end
    end
    req_valid = '0;
    n_checks++; if (job_count !== 16'd4) $display("FAIL rr_job_count got=%0d exp=4", job_count); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_gappy();
    int r, g0;
    logic [15:0] jc0;
    set_rev(3);
    g0 = gap_err; jc0 = job_count;
    req_valid[3] = 1'b1;
    do_job(3, 0, 1'b0, r);
    n_checks++; if (r !== 3) $display("FAIL gap_winner got=%0d exp=3", r); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got[k] !== exp_rev[k]) $display("FAIL gap_r%0d got=%h exp=%h", k, got[k], exp_rev[k]); else n_pass++;
    end
    n_checks++; if (last_run !== 21) $display("FAIL gap_mdv_run got=%0d exp=21", last_run); else n_pass++;
    n_checks++; if (gap_err !== g0) $display("FAIL gap_burst_gaps got=%0d exp=%0d", gap_err, g0); else n_pass++;
    n_checks++; if (job_count !== jc0 + 16'd1) $display("FAIL gap_job_count got=%0d exp=%0d", job_count, jc0 + 16'd1); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int r, rd0;
    set_diag(2, 32'h40400000);
    rd0 = rd_cnt;
    req_valid[2] = 1'b1;
    do_job(1, 10, 1'b0, r);
    n_checks++; if (r !== 2) $display("FAIL bp_winner got=%0d exp=2", r); else n_pass++;
    n_checks++; if (unstable !== 0) $display("FAIL bp_stable got=%0d changes exp=0", unstable); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (gotl[k] !== (k == 3)) $display("FAIL bp_last%0d got=%b exp=%b", k, gotl[k], (k == 3)); else n_pass++;
      n_checks++; if (got[k] !== exp_x3[k]) $display("FAIL bp_r%0d got=%h exp=%h", k, got[k], exp_x3[k]); else n_pass++;
    end
    n_checks++; if (rd_at_hs - rd0 !== 1) $display("FAIL bp_read_done_first got=%0d exp=1", rd_at_hs - rd0); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int r, tmo, m0;
    logic [15:0] jc0;
    set_diag(1, 32'h40000000);
    m0 = mdv_cnt; jc0 = job_count;
    req_valid[1] = 1'b1;
    tmo = 0;
    while (grant == '0 && tmo < 50) begin @(negedge clk); tmo++; end
    n_checks++; if (grant !== 4'b0010) $display("FAIL ab_grant got=%b exp=0010", grant); else n_pass++;
    feed_words(1, 7, 1);
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (grant !== '0 || busy !== 1'b0) $display("FAIL ab_cleared got=%b/%b exp=0000/0", grant, busy); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (mdv_cnt !== m0) $display("FAIL ab_no_mdv got=%0d exp=%0d", mdv_cnt, m0); else n_pass++;
    n_checks++; if (job_count !== jc0) $display("FAIL ab_job_count got=%0d exp=%0d", job_count, jc0); else n_pass++;
    req_valid = '1;
    do_job(1, 0, 1'b0, r);
    req_valid = '0;
    n_checks++; if (r !== 2) $display("FAIL ab_next_ptr got=%0d exp=2", r); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got[k] !== exp_x3[k]) $display("FAIL ab_r%0d got=%h exp=%h", k, got[k], exp_x3[k]); else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int r, cnt, t;
    set_diag(0, 32'h3F800000);
    req_valid[0] = 1'b1;
    t = 0;
    while (grant == '0 && t < 50) begin @(negedge clk); t++; end
    n_checks++; if (grant !== 4'b0001) $display("FAIL mb_grant got=%b exp=0001", grant); else n_pass++;
    feed_words(0, 20, 1);
    cnt = 0; t = 0;
    while (cnt < 12 && t < 200) begin
      if (mv_data_valid) cnt++;
      if (cnt < 12) begin @(negedge clk); t++; end
    end
    n_checks++; if (mv_data !== 32'h3F800000) $display("FAIL mb_word10 got=%h exp=3f800000", mv_data); else n_pass++;
    iRstn = 1'b0; req_valid = '0;
    @(negedge clk);
    n_checks++; if (grant !== '0 || busy !== 1'b0 || req_wready !== 1'b0) $display("FAIL mb_rst_ctrl got=%b/%b/%b exp=0", grant, busy, req_wready); else n_pass++;
    n_checks++; if (mv_data_valid !== 1'b0 || mv_data !== '0 || mv_read_done !== 1'b0) $display("FAIL mb_rst_mv got=%b/%h/%b exp=0", mv_data_valid, mv_data, mv_read_done); else n_pass++;
    n_checks++; if (rsp_valid !== '0 || job_count !== 16'd0) $display("FAIL mb_rst_rsp got=%b/%0d exp=0", rsp_valid, job_count); else n_pass++;
    iRstn = 1'b1;
    @(negedge clk);
    set_diag(1, 32'h40000000);
    req_valid[1] = 1'b1;
    do_job(1, 0, 1'b0, r);
    n_checks++; if (r !== 1) $display("FAIL mb_fresh_winner got=%0d exp=1", r); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got[k] !== exp_x2[k]) $display("FAIL mb_r%0d got=%h exp=%h", k, got[k], exp_x2[k]); else n_pass++;
    end
    n_checks++; if (job_count !== 16'd1) $display("FAIL mb_job_count got=%0d exp=1", job_count); else n_pass++;
  endtask

  initial begin
    iRstn = 1'b0; req_valid = '0; req_wvalid = '0; req_wdata = '0; rsp_ready = '0;
    test_reset();
    test_identity();
    test_round_robin();
    test_gappy();
    test_backpressure();
    test_abort();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mvmul_arbiter.md
# mvmul_arbiter

Round-robin arbiter and sequencer that shares one `mul4x4_4x1_wrapper` (single-precision 4x4 matrix by 4x1 vector unit) between `NUM_REQ` requesters in the render pipeline. It grants one requester at a time and buffers that requester's 20 input words. It then replays them to the wrapper as one gapless burst, captures the 4 result words, releases the wrapper and returns the results to the granted requester with backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: word width; fixed at 32 (IEEE-754 single).
- `iClk` in 1: the block's single clock.
- `iRstn` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: requester i wants a job; hold high until its `rsp_last` handshake.
- `req_wvalid` in NUM_REQ: requester i presents an input word.
- `req_wdata` in NUM_REQ*32: packed input words; slice i belongs to requester i.
- `req_wready` out 1: accept strobe for the granted requester's word.
- `grant` out NUM_REQ: one-hot grant, or all zeros.
- `rsp_valid` out NUM_REQ: one-hot result valid, only the granted bit.
- `rsp_data` out 32: result word.
- `rsp_last` out 1: marks result word 3.
- `rsp_ready` in NUM_REQ: result accept from requester i.
- `mv_ready` in 1: wrapper `ready`.
- `mv_data_valid` out 1: wrapper `data_valid`.
- `mv_data` out 32: wrapper `data`.
- `mv_calc_done` in 1: wrapper `calc_done`.
- `mv_result` in 32: wrapper `result`.
- `mv_read_done` out 1: wrapper `read_done`.
- `busy` out 1: high whenever state is not ARB.
- `job_count` out 16: completed jobs; wraps from 0xFFFF to 0.

## Operation
- Input word order is row-major matrix m00,m01..m33 (words 0–15), then vector v0..v3 (words 16–19). Output order is r0..r3.
- **ARB**
  - Among set `req_valid` bits, pick the first at or after pointer `rr_ptr` (mod NUM_REQ). `rr_ptr` resets to 0.
  - Register the pick into `grant`, set `rr_ptr` to winner+1 mod NUM_REQ, then go to COLLECT.
- **COLLECT**
  - `req_wready` = 1. Each cycle with `req_wvalid[g]` high stores `req_wdata` slice g into `in_buf[wcnt]` and increments `wcnt`.
  - Gaps from the requester are allowed.
  - After word 19, `req_wready` drops and the state goes to START.
  - If `req_valid[g]` drops during COLLECT, the job aborts: grant is cleared, the state returns to ARB, the wrapper is untouched, and `rr_ptr` keeps its advanced value.
- **START**
  - Wait for `mv_ready` = 1, then drive `mv_data_valid` = 1 with `mv_data` = 0 for one cycle.
  - This is the wrapper's IDLE-exit strobe; the word is not loaded.
- **BURST**
  - Drive `in_buf[0..19]` on 20 consecutive cycles with `mv_data_valid` = 1. No gaps are permitted, because the wrapper advances its load state without checking `data_valid`.
  - From START onward, `req_valid` is ignored.
- **WAIT_RES**
  - `mv_data_valid` = 0.
  - On each cycle with `mv_calc_done` = 1, store `mv_result` into `out_buf[rcnt]` and increment `rcnt`.
  - After 4 captures, go to RELEASE. `mv_calc_done` has no backpressure, so every calc_done cycle must be captured.
- **RELEASE**
  - Drive `mv_read_done` = 1 for exactly one cycle, then go to RETURN.
- **RETURN**
  - `rsp_valid[g]` = 1 with `rsp_data` = `out_buf[ocnt]` and `rsp_last` = (`ocnt` == 3).
  - `ocnt` advances on `rsp_ready[g]`.
  - On the last handshake: `job_count` increments, `grant` clears, and the state goes to ARB.
- Unused `mv_data` and `rsp_data` are held at 0 outside their active states.

## Timing
- **Reset:** every output is 0, including `grant`, `req_wready`, `mv_data_valid`, `mv_read_done`, `rsp_valid`, `rsp_last`, `busy` and `job_count`. FSM = ARB, `rr_ptr` = 0, all counters = 0.
- **Reset mid-job:** the same state is reached on the next edge. The wrapper is reset from the same reset source, so no drain is needed.
- **Grant timing:** `grant` asserts 1 cycle after `req_valid` is sampled in ARB.
- **START:** START is 1 cycle when `mv_ready` is already high.
- **Burst:** the burst occupies exactly 20 cycles, with `mv_data_valid` high for 21 consecutive cycles in total (START plus BURST).
- **Minimum wrapper occupancy:** start strobe, then 20 words, then compute, then 4 capture cycles, then 1 release cycle.
- **Release:** `mv_read_done` is high for the single cycle after the 4th capture. The wrapper shows `ready` = 1 two cycles later.
- **Back-to-back jobs:** ARB needs 1 cycle after the final `rsp` handshake before the next grant.
- **Simultaneous requests:** resolved purely by `rr_ptr`. A requester that keeps `req_valid` high never wins twice in a row while another requester is waiting.
- **`rsp_ready` low:** holds `rsp_data` and `rsp_last` stable with no limit.

## Structure
- Package `mvmul_pkg` holds:
  - the `mvarb_state_t` enum (ARB, COLLECT, START, BURST, WAIT_RES, RELEASE, RETURN);
  - `MV_IN_WORDS` = 20;
  - `MV_OUT_WORDS` = 4.
- Sub-module `rr_arbiter`: combinational one-hot round-robin pick from `req` and `ptr`, with a `NUM_REQ` parameter.
- Buffers are 20x32 (`in_buf`) and 4x32 (`out_buf`) register arrays. Counters are 5-bit `wcnt`/`bcnt` and 2-bit `rcnt`/`ocnt`.

## Test plan
- **Identity matrix (requester 0):** identity matrix (0x3F800000 on the diagonal) and vector {0x3F800000, 0x40000000, 0x40400000, 0x40800000}.
  - Expect r0..r3 equal to the same four words and `job_count` = 1.
  - Expect `mv_data_valid` high for 21 consecutive cycles.
- **Round-robin:** requesters 0 and 2 request in the same cycle and hold `req_valid`.
  - Expect grant order 0, 2, 0, 2 across four jobs.
  - Check each requester receives its own results, e.g. a scale-by-2.0 matrix (0x40000000 diagonal) gives doubled values.
- **Gappy input:** requester supplies words with `req_wvalid` on every third cycle.
  - Expect the wrapper burst to remain 20 contiguous cycles and the results to be correct.
- **Response backpressure:** `rsp_ready` low for 10 cycles per word.
  - Expect `rsp_data` stable and `rsp_last` only on word 3.
  - Expect `mv_read_done` already pulsed before the first response handshake.
- **Abort:** requester 1 drops `req_valid` after 7 words.
  - Expect `grant` to clear, no `mv_data_valid` activity and `job_count` unchanged.
  - Expect the next request to be served with `rr_ptr` = 2.
- **Reset mid-burst:** assert `iRstn` = 0 at BURST word 10.
  - Expect all outputs 0 on the next edge.
  - Expect a fresh job after reset to complete correctly.
